// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared constants for the UART receive path.
//   - entry layout helpers: a stored frame is {trans_error, data_error, data}
//   - DROP_CNT_W: width of the saturating lost/discarded frame counter
package uart_rx_pkg;

  localparam int DATA_SIZE_DEF = 8;
  localparam int ERR_W         = 2;
  localparam int ENTRY_W       = DATA_SIZE_DEF + ERR_W;
  localparam int DROP_CNT_W    = 8;

  // Entry width for a given receiver data width.
  function automatic int entry_w(input int data_size);
    return data_size + ERR_W;
  endfunction

  // Bit index of the trans_error flag inside an entry.
  function automatic int trans_bit(input int data_size);
    return data_size + 1;
  endfunction

  // Bit index of the data_error (parity) flag inside an entry.
  function automatic int data_err_bit(input int data_size);
    return data_size;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// uart_rx_fifo_mem: simple dual-port register array, DEPTH x WIDTH.
//   gclk    : clock
//   we      : write enable, wr_data stored at wr_addr on the clock edge
//   re      : read enable, rd_q loaded from rd_addr on the clock edge
// No reset on storage or rd_q. A same-address read and write in one cycle
// returns the old contents (read-before-write), which the FIFO relies on
// when it is full and reads/writes the same slot together.
module uart_rx_fifo_mem #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 10,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              gclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge gclk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge gclk) begin
    if (re) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: frame buffer behind the UART receiver.
//   sys_clk, rst          : clock, async active-low reset
//   data_in, trans_error,
//   data_error, frame_done: receiver outputs; a frame is captured on the
//                           rising edge of frame_done
//   rd_en                 : consumer read request (ignored while empty)
//   rd_data, rd_trans_err,
//   rd_data_err, rd_valid : read result, valid one cycle after the accepted read
//   empty, full, count    : occupancy
//   overflow, drop_cnt    : sticky overflow flag, saturating lost-frame count
//   clr_status            : clears overflow/drop_cnt (a same-cycle drop still counts)
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int DEPTH     = 16,
  parameter int DROP_BAD  = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [DATA_SIZE-1:0]  data_in,
  input  logic                  frame_done,
  input  logic                  trans_error,
  input  logic                  data_error,
  input  logic                  rd_en,
  output logic [DATA_SIZE-1:0]  rd_data,
  output logic                  rd_trans_err,
  output logic                  rd_data_err,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_W:0]       count,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_cnt,
  input  logic                  clr_status
);

  localparam int EW   = entry_w(DATA_SIZE);
  localparam int TB_I = trans_bit(DATA_SIZE);
  localparam int DB_I = data_err_bit(DATA_SIZE);
  localparam int CW   = ADDR_W + 1;

  logic              fd_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0]     wr_entry, mem_q;
  logic              have_data;  // rd_data/flags show mem_q only after a read since reset
  logic              wr_req, keep, wr_acc, rd_acc, lost, drop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));

  assign wr_req   = frame_done & ~fd_q;
  assign keep     = (DROP_BAD == 0) || !(trans_error || data_error);
  assign rd_acc   = rd_en & ~empty;
  assign wr_acc   = wr_req & keep & (~full | rd_acc);
  assign lost     = wr_req & keep & full & ~rd_acc;
  assign drop     = lost | (wr_req & ~keep);
  assign wr_entry = {trans_error, data_error, data_in};

  uart_rx_fifo_mem #(.DEPTH(DEPTH), .WIDTH(EW), .ADDR_W(ADDR_W)) u_mem (
    .gclk    (sys_clk),
    .we      (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (wr_entry),
    .re      (rd_acc),
    .rd_addr (rd_ptr),
    .rd_q    (mem_q)
  );

  // Storage is unreset, so the read register is masked to zero until the
  // first accepted read after reset.
  assign rd_data      = have_data ? mem_q[DATA_SIZE-1:0] : '0;
  assign rd_trans_err = have_data & mem_q[TB_I];
  assign rd_data_err  = have_data & mem_q[DB_I];

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      fd_q      <= 1'b1;  // frame_done high out of reset is not a new frame
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rd_valid  <= 1'b0;
      have_data <= 1'b0;
      overflow  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      fd_q     <= frame_done;
      rd_valid <= rd_acc;
      if (rd_acc) begin
        have_data <= 1'b1;
        rd_ptr    <= rd_ptr + ADDR_W'(1);
      end
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Clear wins over history, but an event in the same cycle survives it.
      if (clr_status) begin
        overflow <= lost;
        drop_cnt <= drop ? DROP_CNT_W'(1) : '0;
      end else begin
        if (lost) overflow <= 1'b1;
        if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       frame_done, trans_error, data_error, rd_en, clr_status;

  logic [7:0] o_data [2];
  logic       o_te [2], o_de [2], o_valid [2], o_empty [2], o_full [2], o_ovf [2];
  logic [4:0] o_cnt [2];
  logic [7:0] o_dcnt [2];

  int tests = 0;
  int fails = 0;

  logic [9:0] log0 [$];
  logic [9:0] log1 [$];

  always #5 sys_clk = ~sys_clk;

  // Instance 0 keeps bad frames, instance 1 discards them.
  uart_rx_fifo #(.DATA_SIZE(8), .DEPTH(16), .DROP_BAD(0)) dut0 (
    .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .frame_done(frame_done),
    .trans_error(trans_error), .data_error(data_error), .rd_en(rd_en),
    .rd_data(o_data[0]), .rd_trans_err(o_te[0]), .rd_data_err(o_de[0]),
    .rd_valid(o_valid[0]), .empty(o_empty[0]), .full(o_full[0]), .count(o_cnt[0]),
    .overflow(o_ovf[0]), .drop_cnt(o_dcnt[0]), .clr_status(clr_status));

  uart_rx_fifo #(.DATA_SIZE(8), .DEPTH(16), .DROP_BAD(1)) dut1 (
    .sys_clk(sys_clk), .rst(rst), .data_in(data_in), .frame_done(frame_done),
    .trans_error(trans_error), .data_error(data_error), .rd_en(rd_en),
    .rd_data(o_data[1]), .rd_trans_err(o_te[1]), .rd_data_err(o_de[1]),
    .rd_valid(o_valid[1]), .empty(o_empty[1]), .full(o_full[1]), .count(o_cnt[1]),
    .overflow(o_ovf[1]), .drop_cnt(o_dcnt[1]), .clr_status(clr_status));

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue-level reference: a frame list, the last value popped, and status.
  for (genvar g = 0; g < 2; g++) begin : m
    localparam bit DB = (g == 1);
    logic [9:0] q [$];
    logic [9:0] ent;
    bit         vld, ovf, fdq;
    int         dcnt;

    always @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
        q.delete(); ent = '0; vld = 0; ovf = 0; dcnt = 0; fdq = 1;
      end else begin : step
        bit req, keep, racc, is_full, is_lost, is_drop;
        req     = frame_done && !fdq;
        fdq     = frame_done;
        keep    = !(DB && (trans_error || data_error));
        is_full = (q.size() == 16);
        racc    = rd_en && (q.size() != 0);
        vld     = racc;
        if (racc) ent = q.pop_front();
        is_lost = req && keep && is_full && !racc;
        if (req && keep && !is_lost) q.push_back({trans_error, data_error, data_in});
        is_drop = is_lost || (req && !keep);
        if (clr_status) begin
          ovf  = is_lost;
          dcnt = is_drop ? 1 : 0;
        end else begin
          if (is_lost) ovf = 1;
          if (is_drop && dcnt < 255) dcnt++;
        end
      end
    end

    always @(negedge sys_clk) begin
      if (rst) begin
        check($sformatf("u%0d_rd_valid", g), int'(o_valid[g]), int'(vld));
        check($sformatf("u%0d_rd_data", g), int'(o_data[g]), int'(ent[7:0]));
        check($sformatf("u%0d_rd_data_err", g), int'(o_de[g]), int'(ent[8]));
        check($sformatf("u%0d_rd_trans_err", g), int'(o_te[g]), int'(ent[9]));
        check($sformatf("u%0d_count", g), int'(o_cnt[g]), q.size());
        check($sformatf("u%0d_empty", g), int'(o_empty[g]), int'(q.size() == 0));
        check($sformatf("u%0d_full", g), int'(o_full[g]), int'(q.size() == 16));
        check($sformatf("u%0d_overflow", g), int'(o_ovf[g]), int'(ovf));
        check($sformatf("u%0d_drop_cnt", g), int'(o_dcnt[g]), dcnt);
      end
    end
  end

  always @(negedge sys_clk) begin
    if (o_valid[0]) log0.push_back({o_te[0], o_de[0], o_data[0]});
    if (o_valid[1]) log1.push_back({o_te[1], o_de[1], o_data[1]});
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic te, input logic de);
    data_in = d; trans_error = te; data_error = de; frame_done = 1'b1;
    tick();
    frame_done = 1'b0; trans_error = 1'b0; data_error = 1'b0;
    tick();
  endtask

  task automatic read_n(input int n);
    rd_en = 1'b1;
    repeat (n) tick();
    rd_en = 1'b0;
    tick();
  endtask

  task automatic chk_log(input string nm, input int g, input logic [9:0] exp [$]);
    logic [9:0] got [$];
    if (g == 0) got = log0; else got = log1;
    check({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", nm, i), int'(got[i]), int'(exp[i]));
  endtask

  initial begin
    logic [9:0] exp [$];
    rst = 1'b0; frame_done = 1'b1; data_in = '0; trans_error = 0; data_error = 0;
    rd_en = 0; clr_status = 0;
    #2;
    check("rst_count", int'(o_cnt[0]), 0);
    check("rst_empty", int'(o_empty[0]), 1);
    check("rst_rd_valid", int'(o_valid[0]), 0);
    repeat (2) tick();
    rst = 1'b1;

    // frame_done held high across reset release: no capture
    repeat (5) tick();
    check("hold_count", int'(o_cnt[0]), 0);
    check("hold_empty", int'(o_empty[1]), 1);
    check("hold_no_read", log0.size(), 0);
    frame_done = 1'b0;
    tick();

    // three clean frames, three back-to-back reads
    send(8'hA5, 0, 0); send(8'h3C, 0, 0); send(8'hFF, 0, 0);
    check("three_count", int'(o_cnt[0]), 3);
    read_n(3);
    exp = '{10'h0A5, 10'h03C, 10'h0FF};
    chk_log("three_data", 0, exp);
    check("three_empty", int'(o_empty[0]), 1);
    check("three_count0", int'(o_cnt[0]), 0);

    // fill to 16, 17th is lost
    for (int i = 0; i < 16; i++) send(8'(i), 0, 0);
    check("fill_full", int'(o_full[0]), 1);
    check("fill_count", int'(o_cnt[0]), 16);
    send(8'h10, 0, 0);
    check("ovf_flag", int'(o_ovf[0]), 1);
    check("ovf_drop_cnt", int'(o_dcnt[0]), 1);
    check("ovf_count", int'(o_cnt[0]), 16);

    // clear and a drop in the same cycle: the drop survives the clear
    data_in = 8'h11; frame_done = 1'b1; clr_status = 1'b1;
    tick();
    frame_done = 1'b0; clr_status = 1'b0;
    tick();
    check("clrdrop_ovf", int'(o_ovf[0]), 1);
    check("clrdrop_cnt", int'(o_dcnt[0]), 1);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    check("clr_ovf", int'(o_ovf[0]), 0);
    check("clr_cnt", int'(o_dcnt[1]), 0);

    // full + write + read together: both accepted
    log0.delete(); log1.delete();
    data_in = 8'h55; frame_done = 1'b1; rd_en = 1'b1;
    tick();
    frame_done = 1'b0; rd_en = 1'b0;
    tick();
    check("fwr_count", int'(o_cnt[0]), 16);
    check("fwr_ovf", int'(o_ovf[0]), 0);
    read_n(16);
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(10'(i));
    exp.push_back(10'h055);
    chk_log("drain", 0, exp);
    check("drain_empty", int'(o_empty[0]), 1);

    // bad frames: kept by instance 0, discarded by instance 1
    log0.delete(); log1.delete();
    send(8'h11, 0, 1); send(8'h22, 0, 0); send(8'h33, 1, 0);
    check("bad_count_keep", int'(o_cnt[0]), 3);
    check("bad_count_drop", int'(o_cnt[1]), 1);
    check("bad_drop_cnt", int'(o_dcnt[1]), 2);
    check("bad_no_ovf", int'(o_ovf[1]), 0);
    check("bad_keep_drop_cnt", int'(o_dcnt[0]), 0);
    read_n(3);
    exp = '{10'h111, 10'h022, 10'h233};
    chk_log("bad_keep", 0, exp);
    exp = '{10'h022};
    chk_log("bad_drop", 1, exp);

    // async reset in the middle of traffic
    for (int i = 1; i <= 5; i++) send(8'(i), 0, 0);
    check("mid_count", int'(o_cnt[0]), 5);
    #3 rst = 1'b0;
    #1;
    check("arst_count", int'(o_cnt[0]), 0);
    check("arst_empty", int'(o_empty[0]), 1);
    check("arst_ovf", int'(o_ovf[0]), 0);
    check("arst_valid", int'(o_valid[0]), 0);
    check("arst_drop_cnt", int'(o_dcnt[1]), 0);
    tick();
    rst = 1'b1;
    tick();
    log0.delete(); log1.delete();
    send(8'h7E, 0, 0);
    read_n(1);
    exp = '{10'h07E};
    chk_log("post_rst", 0, exp);
    chk_log("post_rst_b", 1, exp);

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
